// File: rtl/y_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y_alu_pkg
//  Description : Shared opcode definitions for the y_alu datapath ALU.
//                - op_t    : 3-bit operation select encoding
//                - OP_W    : opcode width
//                - op_uses_sub() : selects the subtract path of the shared
//                                  adder (SUB and SLT both need a - b)
//  Revision    : 1.0 - initial release
// ============================================================================
package y_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  // SLT is evaluated as a subtraction so both SUB and SLT steer the
  // shared adder into a + ~b + 1 mode.
  function automatic logic op_uses_sub(input logic [OP_W-1:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/y_alu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : y_arith
//  Description : Combinational WIDTH-bit add/subtract unit shared by the
//                ADD, SUB and SLT operations of y_alu.
//                Ports:
//                  a         in   WIDTH  operand A
//                  b         in   WIDTH  operand B
//                  sub       in   1      0: a + b, 1: a + ~b + 1
//                  sum       out  WIDTH  result modulo 2^WIDTH
//                  carry_out out  1      carry out of the MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module y_arith #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
  assign w_b_eff = sub ? ~b : b;
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};

  assign sum       = w_full[WIDTH-1:0];
  assign carry_out = w_full[WIDTH];

endmodule
`default_nettype wire

// File: rtl/y_alu.sv
`default_nettype none
// ============================================================================
//  Module      : y_alu
//  Description : Single-cycle-latency registered ALU (AND, OR, ADD, SUB,
//                unsigned SLT) with registered zero flag.
//                Ports:
//                  clk       in   1      rising-edge clock
//                  rst_n     in   1      asynchronous active-low reset
//                  in_valid  in   1      a/b/op valid this cycle
//                  a         in   WIDTH  operand A
//                  b         in   WIDTH  operand B
//                  op        in   3      operation select (op_t)
//                  z         out  WIDTH  registered result
//                  ex        out  1      registered zero flag (z == 0)
//                  out_valid out  1      z/ex hold a result from a valid input
//  Revision    : 1.0 - initial release
// ============================================================================
module y_alu
  import y_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] z,
  output logic             ex,
  output logic             out_valid
);

  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;

  logic [WIDTH-1:0] r_z;
  logic             r_ex;
  logic             r_out_valid;

  assign w_sub = op_uses_sub(op);

  y_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .a         (a),
    .b         (b),
    .sub       (w_sub),
    .sum       (w_sum),
    .carry_out (w_carry)
  );

  // In subtract mode a missing carry-out means the operation borrowed,
  // which is exactly the unsigned a < b condition.
  assign w_slt = {{(WIDTH-1){1'b0}}, ~w_carry};

  always_comb begin
    w_result = '0;
    case (op)
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_sum;
      OP_SLT:  w_result = w_slt;
      default: w_result = '0;
    endcase
  end

  // Zero flag comes from the same value being registered into z, so the
  // two registers can never disagree.
  assign w_zero = (w_result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z         <= '0;
      r_ex        <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_z  <= w_result;
        r_ex <= w_zero;
      end
    end
  end

  assign z         = r_z;
  assign ex        = r_ex;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_y_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y_alu
//  Description : Self-checking directed testbench for y_alu (WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [WIDTH-1:0] z;
  logic             ex;
  logic             out_valid;

  int n_pass;
  int n_total;

  y_alu #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .z         (z),
    .ex        (ex),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model written from the opcode table.
  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (o)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one input set at the falling edge, then move to just after the
  // following rising edge where the registered result is visible.
  task automatic issue(input logic v, input logic [2:0] o,
                       input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a  = $urandom;
      b  = $urandom;
      op = 3'b001;
    end
    @(posedge clk);
    #1;
    n_total++;
    if (z !== 32'd0) $display("FAIL reset_z: got %h expected %h", z, 32'd0);
    else n_pass++;
    n_total++;
    if (ex !== 1'b1) $display("FAIL reset_ex: got %b expected 1", ex);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_logic;
    issue(1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    n_total++;
    if (z !== 32'h00F0_1234 || ex !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL and: got z=%h ex=%b ov=%b expected z=00f01234 ex=0 ov=1", z, ex, out_valid);
    else n_pass++;
    issue(1'b1, 3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF);
    n_total++;
    if (z !== 32'hFFF0_FFFF || ex !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL or: got z=%h ex=%b ov=%b expected z=fff0ffff ex=0 ov=1", z, ex, out_valid);
    else n_pass++;
  endtask

  task automatic test_arith;
    issue(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
    n_total++;
    if (z !== 32'd0 || ex !== 1'b1)
      $display("FAIL add_wrap: got z=%h ex=%b expected z=00000000 ex=1", z, ex);
    else n_pass++;
    issue(1'b1, 3'b010, 32'd5, 32'd7);
    n_total++;
    if (z !== 32'd12 || ex !== 1'b0)
      $display("FAIL add_5_7: got z=%h ex=%b expected z=0000000c ex=0", z, ex);
    else n_pass++;
    issue(1'b1, 3'b110, 32'd0, 32'd1);
    n_total++;
    if (z !== 32'hFFFF_FFFF || ex !== 1'b0)
      $display("FAIL sub_0_1: got z=%h ex=%b expected z=ffffffff ex=0", z, ex);
    else n_pass++;
    issue(1'b1, 3'b110, 32'h1234_5678, 32'h0000_0679);
    n_total++;
    if (z !== 32'h1234_4FFF || ex !== 1'b0)
      $display("FAIL sub_gen: got z=%h ex=%b expected z=12344fff ex=0", z, ex);
    else n_pass++;
    issue(1'b1, 3'b110, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    n_total++;
    if (z !== 32'd0 || ex !== 1'b1)
      $display("FAIL sub_equal: got z=%h ex=%b expected z=00000000 ex=1", z, ex);
    else n_pass++;
  endtask

  task automatic test_slt;
    issue(1'b1, 3'b111, 32'd1, 32'hFFFF_FFFF);
    n_total++;
    if (z !== 32'd1 || ex !== 1'b0)
      $display("FAIL slt_1_max: got z=%h ex=%b expected z=00000001 ex=0", z, ex);
    else n_pass++;
    issue(1'b1, 3'b111, 32'h8000_0000, 32'd1);
    n_total++;
    if (z !== 32'd0 || ex !== 1'b1)
      $display("FAIL slt_msb_1: got z=%h ex=%b expected z=00000000 ex=1", z, ex);
    else n_pass++;
    issue(1'b1, 3'b111, 32'd0, 32'hFFFF_FFFF);
    n_total++;
    if (z !== 32'd1)
      $display("FAIL slt_0_max: got z=%h expected z=00000001", z);
    else n_pass++;
    issue(1'b1, 3'b111, 32'd7, 32'd7);
    n_total++;
    if (z !== 32'd0 || ex !== 1'b1)
      $display("FAIL slt_equal: got z=%h ex=%b expected z=00000000 ex=1", z, ex);
    else n_pass++;
  endtask

  task automatic test_unsupported;
    logic [2:0] bad [3];
    bad[0] = 3'b011;
    bad[1] = 3'b100;
    bad[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      // Precede each with a nonzero result so a stale z cannot pass.
      issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0);
      issue(1'b1, bad[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_total++;
      if (z !== 32'd0 || ex !== 1'b1 || out_valid !== 1'b1)
        $display("FAIL unsupported_%b: got z=%h ex=%b ov=%b expected z=00000000 ex=1 ov=1",
                 bad[i], z, ex, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]       ops [5];
    logic [2:0]       o;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] exp_z;
    ops[0] = 3'b000;
    ops[1] = 3'b001;
    ops[2] = 3'b010;
    ops[3] = 3'b110;
    ops[4] = 3'b111;
    for (int i = 0; i < 1000; i++) begin
      o = ops[$urandom_range(0, 4)];
      x = $urandom;
      y = ($urandom_range(0, 1) == 1) ? x : $urandom;
      exp_z = ref_alu(o, x, y);
      issue(1'b1, o, x, y);
      n_total++;
      if (z !== exp_z || ex !== (exp_z == 32'd0) || out_valid !== 1'b1)
        $display("FAIL stream[%0d] op=%b a=%h b=%h: got z=%h ex=%b ov=%b expected z=%h ex=%b ov=1",
                 i, o, x, y, z, ex, out_valid, exp_z, (exp_z == 32'd0));
      else n_pass++;
    end
  endtask

  task automatic test_hold;
    issue(1'b1, 3'b010, 32'h0000_1000, 32'h0000_0234);
    n_total++;
    if (z !== 32'h0000_1234 || out_valid !== 1'b1)
      $display("FAIL hold_setup: got z=%h ov=%b expected z=00001234 ov=1", z, out_valid);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      // Inputs that would give z=0 must be ignored while in_valid is low.
      issue(1'b0, 3'b110, 32'h55, 32'h55);
      n_total++;
      if (z !== 32'h0000_1234 || ex !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL hold[%0d]: got z=%h ex=%b ov=%b expected z=00001234 ex=0 ov=0",
                 i, z, ex, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    issue(1'b1, 3'b001, 32'hA5A5_0000, 32'h0000_5A5A);
    n_total++;
    if (z !== 32'hA5A5_5A5A || out_valid !== 1'b1)
      $display("FAIL async_setup: got z=%h ov=%b expected z=a5a55a5a ov=1", z, out_valid);
    else n_pass++;
    // Another valid op is in flight; assert reset between edges.
    @(negedge clk);
    op = 3'b010;
    a  = 32'd1;
    b  = 32'd2;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (z !== 32'd0 || ex !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL async_reset: got z=%h ex=%b ov=%b expected z=00000000 ex=1 ov=0",
               z, ex, out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (z !== 32'd0 || out_valid !== 1'b0)
      $display("FAIL async_discard: got z=%h ov=%b expected z=00000000 ov=0", z, out_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 3'b010, 32'd1, 32'd2);
    n_total++;
    if (z !== 32'd3 || ex !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL after_reset: got z=%h ex=%b ov=%b expected z=00000003 ex=0 ov=1",
               z, ex, out_valid);
    else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = 3'b000;
    test_reset();
    test_logic();
    test_arith();
    test_slt();
    test_unsupported();
    test_back_to_back();
    test_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y_alu.md
Name: y_alu

Overview:
y_alu is a single-cycle-latency registered ALU for the datapath.
- Operands: two WIDTH-bit values.
- Operations: AND, OR, ADD, SUB or unsigned set-less-than, selected by a 3-bit opcode.
- Outputs: a registered result and a registered zero flag (ex).
- Position: sits between the register-read stage and the writeback/branch-compare logic.

Parameters:
WIDTH, 32, operand and result width in bits (legal range ≥ 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op on a, b, op are valid this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select
z  output  WIDTH  registered result
ex  output  1  registered zero flag, 1 when z == 0
out_valid  output  1  z/ex hold a result computed from a valid input

Behaviour:
- Reset and clocking:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - While rst_n=0: z=0, ex=1, out_valid=0.
  - After release, the first update happens at the next rising clk edge.
- Opcode map; arithmetic wraps modulo 2^WIDTH with no overflow flag or exception:
  - 3'b000: z = a & b
  - 3'b001: z = a | b
  - 3'b010: z = a + b, carry-out discarded
  - 3'b110: z = a - b, computed as a + ~b + 1, borrow discarded
  - 3'b111: z = (a < b) ? 1 : 0. Comparison is UNSIGNED; the result is zero-extended to WIDTH.
  - Any other op (011, 100, 101): z = 0.
- Zero flag:
  - ex = (next z == 0).
  - ex is computed from the same result that is registered into z, so ex and z are always coherent.
  - An unsupported op therefore gives ex=1.
- Latency and handshake:
  - Latency is 1 cycle.
  - On a rising edge with in_valid=1: z/ex capture the result of a, b, op sampled at that edge, and out_valid is set to 1.
  - On a rising edge with in_valid=0: z/ex hold their values and out_valid is set to 0.
  - No backpressure; a new operation may be issued every cycle.
- Boundary conditions:
  - a == b: SUB gives z=0, ex=1; SLT gives 0.
  - ADD 0xFFFFFFFF + 1: z=0, ex=1.
  - SUB 0 - 1: z=0xFFFFFFFF.
  - SLT 0 vs 0xFFFFFFFF: z=1 (unsigned).
  - rst_n asserted mid-stream: outputs go to reset values immediately, asynchronously, and the in-flight result is discarded.
- Datapath structure:
  - One shared adder serves ADD, SUB and SLT.
  - SLT derives from the subtractor's borrow: a < b unsigned ⇔ carry-out of a + ~b + 1 is 0.

Decomposition:
- Package y_alu_pkg holds:
  - op_t, a 3-bit enum with OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111.
  - Constant OP_W=3.
- Sub-module y_arith: combinational WIDTH-bit add/subtract unit.
  - Inputs: a, b, sub.
  - Outputs: sum and carry_out.
  - Serves ADD, SUB and SLT.
- The top level holds the logic/mux, the zero detect and the output registers.

Test Plan:
1. Reset: hold rst_n=0 with random inputs and in_valid=1 → z=0, ex=1, out_valid=0. Assert rst_n=0 mid-operation between clock edges → outputs clear without waiting for a clock edge.
2. Logic: a=0xF0F0_1234, b=0x0FF0_FFFF.
   - op=000 → z=0x00F0_1234, ex=0.
   - op=001 → z=0xFFF0_FFFF.
   - Both appear one cycle after issue, with out_valid=1.
3. Arithmetic:
   - ADD 0xFFFF_FFFF+1 → z=0, ex=1.
   - ADD 5+7 → z=12.
   - SUB 0-1 → z=0xFFFF_FFFF.
   - SUB a-a (a=0xDEAD_BEEF) → z=0, ex=1.
4. SLT unsigned:
   - a=1, b=0xFFFF_FFFF → z=1.
   - a=0x8000_0000, b=1 → z=0.
   - a=b=7 → z=0, ex=1.
5. Unsupported ops 011/100/101 with a=b=0xFFFF_FFFF → z=0, ex=1.
6. Streaming and handshake:
   - Random a, b and op ∈ {000,001,010,110,111}, with b forced equal to a on half the vectors, issued back-to-back for 1000 cycles: each z matches the reference model one cycle later, and ex=(z==0).
   - Drop in_valid for 2 cycles: z/ex hold their values and out_valid=0.
